// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-input priority encoder with fixed or round-robin grant, index + any flag out.
// Latency: one cycle from accept to out_valid.
// Backpressure: single output register; in_ready drops while a result is held by out_ready=0.
module prio_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    output logic [W-1:0] out_index,
    output logic         out_any,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_index_q, out_index_d;
    logic         out_any_q,   out_any_d;
    logic [W-1:0] ptr_q,       ptr_d;

    logic         accept;
    logic         any_req;
    logic [W-1:0] fix_idx;
    logic         low_any;
    logic [W-1:0] low_idx;
    logic [W-1:0] rr_idx;

    // Output register is free when empty or when its result drains this cycle
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
    end

    // Grant search. Round-robin order ptr-1..0 then N-1..ptr is the same as
    // "highest request below ptr, else highest request overall".
    always_comb begin
        any_req = |req;
        fix_idx = '0;
        low_any = 1'b0;
        low_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = W'(i);
            end
            if (req[i] && (W'(i) < ptr_q)) begin
                low_any = 1'b1;
                low_idx = W'(i);
            end
        end
        rr_idx = low_any ? low_idx : fix_idx;
    end

    // Load a fresh result on accept; drop valid once the held result drains
    always_comb begin
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_any_d   = out_any_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_any_d   = any_req;
            out_index_d = mode ? rr_idx : fix_idx;
            // Empty vectors and fixed-mode grants leave the rotation untouched
            if (mode && any_req) begin
                ptr_d = rr_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset overriding any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_any_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_any_q   <= out_any_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_any   = out_any_q;

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
Parametrised N-to-log2(N) priority encoder with a registered output stage and valid/ready handshakes on both sides. It has two grant modes: fixed priority (highest index wins) and round-robin (the last winner drops to lowest priority). It also reports an explicit "no request" flag. It sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
N, 8, number of request inputs; integer >= 2, need not be a power of two.
W, $clog2(N), width of the index output; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  N  request vector; bit i = request from source i
in_valid  input  1  req is valid this cycle
in_ready  output  1  block can accept req this cycle
mode  input  1  0 = fixed priority, 1 = round-robin; sampled with req on acceptance
out_index  output  W  encoded index of the granted request
out_any  output  1  1 = at least one req bit was set in the accepted vector
out_valid  output  1  out_index/out_any are valid
out_ready  input  1  downstream accepts the output this cycle

Behaviour:
- Reset:
  - Everything is synchronous: rst is sampled on the clk rising edge and overrides all other activity, including a transfer in flight.
  - After reset: out_valid=0, out_index=0, out_any=0, internal last-grant pointer ptr=0.
  - in_ready=1 in the first cycle after reset.
- Handshake rules:
  - in_ready = !out_valid || out_ready (combinational, single-entry output register).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Latency: accept in cycle t, then out_valid=1 with the result in cycle t+1.
  - Accept and output transfer in the same cycle: the register reloads with the new result and out_valid stays 1.
  - Transfer with no accept: out_valid goes to 0.
  - While out_valid=1 and out_ready=0: out_index, out_any and out_valid hold stable, and in_ready=0.
- Fixed mode (mode=0):
  - out_index = highest i with req[i]=1.
  - ptr is not updated.
- Round-robin mode (mode=1):
  - Search order is ptr-1, ptr-2, ..., 0, N-1, ..., ptr, with wrap modulo N.
  - With ptr=0 the order is N-1 down to 0, i.e. identical to fixed mode.
  - On an accept with out_any=1, ptr := granted index.
- All-zero req:
  - out_any=0 and out_index=0.
  - out_valid still asserts; the response is not dropped.
  - ptr is unchanged.
- mode is evaluated per accepted vector:
  - Switching mode keeps ptr.
  - Returning to round-robin resumes from the retained ptr.
- Non-power-of-two N: indices >= N never appear on out_index, and ptr wraps at N, not at 2^W.
- in_valid=0: no state change apart from the output handshake.
- Values on req and mode outside an accept are don't-care.

Test Plan:
1. N=8, rst held 2 cycles then released, out_ready=1 -> out_valid=0, out_index=0, out_any=0, in_ready=1 after reset.
2. Fixed mode, one-hot sweep req=0x01,0x02,...,0x80 on consecutive cycles -> out_index 0..7 each one cycle after accept, out_any=1; then req=0x00 -> out_any=0, out_index=0, out_valid=1.
3. Fixed mode, req=0x0A -> out_index=3; req=0xFF -> out_index=7.
4. Round-robin, req=0x81 repeated 4 times from reset -> out_index 7,0,7,0. Then req=0x55 from ptr=0 -> 6. Then req=0x55 again -> 4.
5. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output held at the first result, no second accept. Then out_ready=1 -> next result one cycle later, no loss or duplication over a random 200-transfer run checked against a reference model.
6. rst asserted mid-stream with out_valid=1 and ptr=5 -> next cycle out_valid=0 and ptr=0 (next round-robin grant for req=0x81 is 7). Also run N=5: req=0x10 -> out_index=4, and round-robin wraps at 5.
